fetch_inst_buffer: RTL and testbench

- Consumer side of the instruction-SRAM fetch interface: takes the next-PC request stream, issues it to the instruction SRAM, captures the read data one cycle later and pairs it with its PC.
- Presents instructions to the decode stage with a valid/allowin handshake, using a 2-entry buffer (output register + skid register).
- Back-pressures the PC calculator through if_allowin.
- Discards in-flight and buffered instructions on a redirect (flush).

---
 rtl/fetch_inst_buffer.sv | 126 ++++++++++++
 tb/tb_fetch_inst_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_buffer.sv
// rtl/fetch_inst_buffer.sv - instruction fetch buffer: SRAM request issue, response capture, 2-entry skid to decode
//
// Requests accepted in cycle N are returned by the SRAM in cycle N+1 and land
// in the output or skid register at the end of that cycle. The output register
// is always older than the skid register, which is always older than the
// in-flight (pending) request. At most two of the three slots are ever occupied.
module fetch_inst_buffer #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = 32'hbfc00000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_req,
  input  logic [DATA_W-1:0] fetch_pc,
  output logic              if_allowin,
  output logic              inst_sram_en,
  output logic [DATA_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              flush,
  input  logic              id_allowin,
  output logic              if_to_id_valid,
  output logic [DATA_W-1:0] if_to_id_inst,
  output logic [DATA_W-1:0] if_to_id_pc
);

  logic              pend_v_q, pend_v_d;
  logic [DATA_W-1:0] pend_pc_q, pend_pc_d;
  logic              out_v_q, out_v_d;
  logic [DATA_W-1:0] out_inst_q, out_inst_d;
  logic [DATA_W-1:0] out_pc_q, out_pc_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_inst_q, skid_inst_d;
  logic [DATA_W-1:0] skid_pc_q, skid_pc_d;

  logic       accept;
  logic       drain;
  logic       out_free;
  logic [1:0] occ;
  logic [1:0] occ_left;

  // Handshake terms: a new request is admitted only if it cannot overflow the two slots
  always_comb begin
    drain    = out_v_q & id_allowin;
    out_free = ~out_v_q | drain;
    occ      = {1'b0, pend_v_q} + {1'b0, out_v_q} + {1'b0, skid_v_q};
    occ_left = occ - {1'b0, drain};
    // A flush empties everything at the edge, so the redirect target always fits
    if_allowin     = flush | (occ_left <= 2'd1);
    accept         = fetch_req & if_allowin;
    inst_sram_en   = accept;
    inst_sram_addr = fetch_pc;
  end

  // Next-state: track the in-flight request and steer the returning data in program order
  always_comb begin
    pend_v_d    = accept;
    pend_pc_d   = pend_pc_q;
    out_v_d     = out_v_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    skid_v_d    = skid_v_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    if (accept) begin
      pend_pc_d = fetch_pc;
    end

    if (flush) begin
      // Everything older than the redirect is dropped, including the response arriving now.
      // A drain in this cycle has already completed on the decode side.
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (out_free && skid_v_q) begin
      // Oldest buffered entry advances; the arriving response backfills the skid
      out_v_d    = 1'b1;
      out_inst_d = skid_inst_q;
      out_pc_d   = skid_pc_q;
      skid_v_d   = pend_v_q;
      if (pend_v_q) begin
        skid_inst_d = inst_sram_rdata;
        skid_pc_d   = pend_pc_q;
      end
    end else if (out_free) begin
      // Output data is only overwritten by a real response, so it stays put during bubbles
      out_v_d = pend_v_q;
      if (pend_v_q) begin
        out_inst_d = inst_sram_rdata;
        out_pc_d   = pend_pc_q;
      end
    end else if (pend_v_q) begin
      // Decode is stalled: park the response behind the held output
      skid_v_d    = 1'b1;
      skid_inst_d = inst_sram_rdata;
      skid_pc_d   = pend_pc_q;
    end
  end

  // State registers with synchronous active-high reset; a pending response is forgotten on reset
  always_ff @(posedge clk) begin
    if (resetn) begin
      pend_v_q    <= 1'b0;
      pend_pc_q   <= '0;
      out_v_q     <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= RESET_PC;
      skid_v_q    <= 1'b0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_pc_q   <= pend_pc_d;
      out_v_q     <= out_v_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      skid_v_q    <= skid_v_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign if_to_id_valid = out_v_q;
  assign if_to_id_inst  = out_inst_q;
  assign if_to_id_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// tb/tb_fetch_inst_buffer.sv - scoreboard bench for fetch_inst_buffer
module tb_fetch_inst_buffer;

  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic        if_allowin;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        flush = 1'b0;
  logic        id_allowin = 1'b0;
  logic        if_to_id_valid;
  logic [31:0] if_to_id_inst;
  logic [31:0] if_to_id_pc;

  always #5 clk = ~clk;

  fetch_inst_buffer #(.DATA_W(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .fetch_req      (fetch_req),
    .fetch_pc       (fetch_pc),
    .if_allowin     (if_allowin),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .flush          (flush),
    .id_allowin     (id_allowin),
    .if_to_id_valid (if_to_id_valid),
    .if_to_id_inst  (if_to_id_inst),
    .if_to_id_pc    (if_to_id_pc)
  );

  // Instruction memory contents: upper half = pc[15:0]^0x1234, lower half = ~pc[15:0]
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  // SRAM: data one cycle after an enabled request, junk otherwise
  always @(posedge clk) inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : 32'hdeadbeef;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake to decode must match the oldest expected instruction
  always @(negedge clk) begin
    if (!resetn && if_to_id_valid && id_allowin) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got pc %h, expected no instruction", if_to_id_pc);
      end else begin
        e = q.pop_front();
        chk("out_pc", if_to_id_pc, e.pc);
        chk("out_inst", if_to_id_inst, e.inst);
      end
    end
  end

  logic [31:0] pc = RST_PC;
  logic        prev_acc = 1'b0;
  logic        prev_fl = 1'b0;
  logic        prev_rst = 1'b1;
  logic [31:0] prev_pc = 32'h0;

  // One clock cycle of stimulus; expected responses are queued one cycle after acceptance
  task automatic cyc(input logic rst, input logic req, input logic dec, input logic fl,
                     input logic [31:0] tgt, input int exp_allow);
    @(posedge clk);
    if (prev_fl || prev_rst) q.delete();
    if (prev_acc && !prev_rst) q.push_back({prev_pc, mem_word(prev_pc)});
    #1;
    resetn     = rst;
    fetch_req  = req;
    id_allowin = dec;
    flush      = fl;
    fetch_pc   = fl ? tgt : pc;
    #1;
    if (exp_allow >= 0) chk("if_allowin", {31'b0, if_allowin}, 32'(exp_allow));
    prev_acc = req & if_allowin;
    prev_fl  = fl;
    prev_rst = rst;
    prev_pc  = fetch_pc;
    if (prev_acc) pc = fetch_pc + 32'd4;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [31:0] p);
    chk({name, "_valid"}, {31'b0, if_to_id_valid}, {31'b0, v});
    if (v) chk({name, "_pc"}, if_to_id_pc, p);
  endtask

  task automatic idle_drain(input string name);
    repeat (3) cyc(0, 0, 1, 0, 0, 1);
    chk({name, "_leftover"}, q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then streaming
    cyc(1, 0, 0, 0, 0, -1);
    cyc(1, 0, 0, 0, 0, -1);
    pc = 32'hbfc00000;
    cyc(0, 1, 1, 0, 0, 1);
    chk("rst_valid", {31'b0, if_to_id_valid}, 32'h0);
    chk("rst_pc", if_to_id_pc, 32'hbfc00000);
    chk("rst_inst", if_to_id_inst, 32'h0);
    cyc(0, 1, 1, 0, 0, 1);
    chk_out("stream_c2", 1'b0, 32'h0);
    cyc(0, 1, 1, 0, 0, 1);
    chk_out("stream_c3", 1'b1, 32'hbfc00000);
    chk("stream_c3_inst", if_to_id_inst, 32'h1234ffff);
    repeat (5) cyc(0, 1, 1, 0, 0, 1);
    idle_drain("stream");

    // Decode stall: out holds ..04, skid holds ..08
    pc = 32'hbfc00000;
    repeat (3) cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk_out("stall_c4", 1'b1, 32'hbfc00004);
    cyc(0, 1, 0, 0, 0, 0);
    chk_out("stall_c5", 1'b1, 32'hbfc00004);
    chk("stall_skid_v", {31'b0, dut.skid_v_q}, 32'h1);
    chk("stall_skid_pc", dut.skid_pc_q, 32'hbfc00008);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 1);
    chk_out("release_c7", 1'b1, 32'hbfc00004);
    cyc(0, 1, 1, 0, 0, 1);
    chk_out("release_c8", 1'b1, 32'hbfc00008);
    cyc(0, 0, 1, 0, 0, 1);
    chk_out("release_c9", 1'b1, 32'hbfc0000c);
    idle_drain("stall");

    // Flush with full buffer
    pc = 32'hbfc00200;
    repeat (3) cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk_out("full_before_flush", 1'b1, 32'hbfc00204);
    cyc(0, 1, 0, 1, 32'hbfc00100, 1);
    cyc(0, 1, 1, 0, 0, 1);
    chk_out("flush_next", 1'b0, 32'h0);
    cyc(0, 0, 1, 0, 0, 1);
    chk_out("flush_target", 1'b1, 32'hbfc00100);
    chk("flush_target_inst", if_to_id_inst, 32'h1334feff);
    idle_drain("flush_full");

    // Flush and drain in the same cycle
    pc = 32'hbfc00400;
    repeat (2) cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 1, 1, 1, 32'hbfc00300, 1);
    chk_out("flush_drain_out", 1'b1, 32'hbfc00400);
    cyc(0, 0, 1, 0, 0, 1);
    chk_out("flush_drain_next", 1'b0, 32'h0);
    cyc(0, 0, 1, 0, 0, 1);
    chk_out("flush_drain_target", 1'b1, 32'hbfc00300);
    chk("flush_drain_inst", if_to_id_inst, 32'h1134fcff);
    idle_drain("flush_drain");

    // Reset mid-operation
    pc = 32'hbfc00500;
    repeat (2) cyc(0, 1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, -1);
    cyc(0, 0, 1, 0, 0, 1);
    chk("midrst_valid", {31'b0, if_to_id_valid}, 32'h0);
    chk("midrst_pc", if_to_id_pc, RST_PC);
    chk("midrst_inst", if_to_id_inst, 32'h0);
    cyc(0, 0, 1, 0, 0, 1);
    chk_out("midrst_after", 1'b0, 32'h0);
    idle_drain("midrst");

    // Bubbles: request every other cycle
    pc = 32'hbfc00600;
    for (int i = 0; i < 10; i++) begin
      cyc(0, (i % 2) == 0, 1, 0, 0, 1);
      chk_out("bubble", (i >= 2) && ((i % 2) == 0), 32'hbfc00600 + 32'((i - 2) * 2));
    end
    idle_drain("bubble");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
